// File: rtl/noc_pkg.sv
// Shared NoC definitions: link width, VC bit position and a width helper.
package noc_pkg;

   localparam int unsigned PACKET_WIDTH = 64;
   localparam int unsigned VC_BIT       = PACKET_WIDTH - 1;

   // Number of bits needed to index v entries (0 for v <= 1).
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = (v > 0) ? v - 1 : 0;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; dout reads as zero while empty.
module sync_fifo_fwft
   import noc_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic [WIDTH-1:0]          din,
   input  logic                      pop,
   output logic [WIDTH-1:0]          dout,
   output logic                      empty,
   output logic                      full,
   output logic [clog2(DEPTH):0]     count
);

   localparam int unsigned AW = clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_en;
   logic             pop_en;

   assign empty   = (count == CW'(0));
   assign full    = (count == CW'(DEPTH));
   assign pop_en  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still takes a push.
   assign push_en = push & (~full | pop_en);
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Storage array; data needs no reset since dout is masked while empty.
   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_en, pop_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mesh_edge_rx.sv
// Edge-of-mesh link sink: one packet buffer per VC, drained into an output FIFO.
module mesh_edge_rx #(
   parameter int unsigned PACKET_WIDTH = noc_pkg::PACKET_WIDTH,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  polarity_in,
   input  logic                                  link_si,
   output logic                                  link_ri,
   input  logic [PACKET_WIDTH-1:0]               link_di,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [PACKET_WIDTH-1:0]               out_data,
   output logic [noc_pkg::clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [CNT_WIDTH-1:0]                  rx_count,
   output logic                                  err_vc
);

   import noc_pkg::*;

   localparam int unsigned VC = PACKET_WIDTH - 1;

   logic [1:0]              vc_full;
   logic [PACKET_WIDTH-1:0] vc_buf [2];
   logic [CNT_WIDTH-1:0]    rx_cnt;
   logic                    err_q;
   logic                    accept;
   logic                    drain;
   logic                    pop;
   logic                    fifo_empty;
   logic                    fifo_full;

   // Fill targets the VC matching polarity; drain takes the opposite one.
   assign link_ri   = ~vc_full[polarity_in];
   assign accept    = link_si & link_ri;
   assign out_valid = ~fifo_empty;
   assign pop       = out_valid & out_ready;
   assign drain     = vc_full[~polarity_in] & (~fifo_full | pop);
   assign rx_count  = rx_count_w();
   assign err_vc    = err_q;

   function automatic logic [CNT_WIDTH-1:0] rx_count_w();
      return rx_cnt;
   endfunction

   // VC payload capture on accept.
   always_ff @(posedge clk) begin
      if (accept) vc_buf[polarity_in] <= link_di;
   end

   // VC occupancy, received-packet counter and sticky VC mismatch flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vc_full <= 2'b00;
         rx_cnt  <= '0;
         err_q   <= 1'b0;
      end else begin
         if (drain) vc_full[~polarity_in] <= 1'b0;
         if (accept) begin
            vc_full[polarity_in] <= 1'b1;
            rx_cnt               <= rx_cnt + CNT_WIDTH'(1);
            if (link_di[VC] != polarity_in) err_q <= 1'b1;
         end
      end
   end

   sync_fifo_fwft #(
      .WIDTH (PACKET_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (drain),
      .din   (vc_buf[~polarity_in]),
      .pop   (pop),
      .dout  (out_data),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_mesh_edge_rx.sv
// Directed and randomized checks of mesh_edge_rx against a queue-based reference.
module tb_mesh_edge_rx;

   logic        clk;
   logic        reset;
   logic        polarity_in;
   logic        link_si;
   logic        link_ri;
   logic [63:0] link_di;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [2:0]  fifo_count;
   logic [15:0] rx_count;
   logic        err_vc;

   int errors = 0;
   int checks = 0;

   // Reference state: two single-packet VC slots and an ordered output queue.
   logic        m_full [2];
   logic [63:0] m_buf  [2];
   logic [63:0] m_q    [$];
   logic [15:0] m_rx;
   logic        m_err;
   logic [63:0] popped [$];

   mesh_edge_rx #(
      .PACKET_WIDTH (64),
      .FIFO_DEPTH   (4),
      .CNT_WIDTH    (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .polarity_in (polarity_in),
      .link_si     (link_si),
      .link_ri     (link_ri),
      .link_di     (link_di),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .fifo_count  (fifo_count),
      .rx_count    (rx_count),
      .err_vc      (err_vc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_full[0] = 1'b0;
      m_full[1] = 1'b0;
      m_q.delete();
      m_rx  = 16'd0;
      m_err = 1'b0;
   endtask

   // One clock: drive at negedge, compare outputs, advance the model, wait for next negedge.
   task automatic cycle(input logic pol, input logic si, input logic [63:0] di, input logic ordy);
      logic acc;
      logic pp;
      logic dr;
      logic [63:0] dv;
      polarity_in = pol;
      link_si     = si;
      link_di     = di;
      out_ready   = ordy;
      #1;
      chk("link_ri",    64'(link_ri),    64'(!m_full[pol]));
      chk("out_valid",  64'(out_valid),  64'(m_q.size() > 0));
      chk("out_data",   out_data,        (m_q.size() > 0) ? m_q[0] : 64'd0);
      chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
      chk("rx_count",   64'(rx_count),   64'(m_rx));
      chk("err_vc",     64'(err_vc),     64'(m_err));
      acc = si && !m_full[pol];
      pp  = (m_q.size() > 0) && ordy;
      dr  = m_full[!pol] && ((m_q.size() < 4) || pp);
      dv  = m_buf[!pol];
      if (pp) popped.push_back(m_q.pop_front());
      if (dr) begin
         m_q.push_back(dv);
         m_full[!pol] = 1'b0;
      end
      if (acc) begin
         m_buf[pol]  = di;
         m_full[pol] = 1'b1;
         m_rx        = m_rx + 16'd1;
         if (di[63] != pol) m_err = 1'b1;
      end
      @(negedge clk);
   endtask

   // Asynchronous reset asserted between edges; outputs must clear at once.
   task automatic mid_reset();
      reset   = 1'b0;
      link_si = 1'b0;
      #1;
      chk("rst_link_ri",    64'(link_ri),    64'd1);
      chk("rst_out_valid",  64'(out_valid),  64'd0);
      chk("rst_out_data",   out_data,        64'd0);
      chk("rst_fifo_count", 64'(fifo_count), 64'd0);
      chk("rst_rx_count",   64'(rx_count),   64'd0);
      chk("rst_err_vc",     64'(err_vc),     64'd0);
      model_clear();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic fill_six();
      for (int i = 0; i < 6; i++)
         cycle(1'(i % 2), 1'b1, 64'h100 + 64'(i) | (64'(i % 2) << 63), 1'b0);
   endtask

   initial begin
      logic [63:0] d;
      logic        p;
      reset       = 1'b0;
      polarity_in = 1'b0;
      link_si     = 1'b0;
      link_di     = 64'd0;
      out_ready   = 1'b0;
      model_clear();
      m_buf[0] = 64'd0;
      m_buf[1] = 64'd0;
      repeat (2) @(negedge clk);
      chk("init_link_ri",   64'(link_ri),   64'd1);
      chk("init_out_valid", 64'(out_valid), 64'd0);
      chk("init_rx_count",  64'(rx_count),  64'd0);
      reset = 1'b1;
      @(negedge clk);

      // Single clean packet on VC0 appears two cycles later.
      cycle(1'b0, 1'b1, 64'h0000_0000_0000_00A5, 1'b1);
      chk("t2_rx_count", 64'(rx_count), 64'd1);
      cycle(1'b1, 1'b0, 64'd0, 1'b0);
      #1;
      chk("t2_valid", 64'(out_valid), 64'd1);
      chk("t2_data",  out_data, 64'h0000_0000_0000_00A5);
      chk("t2_err",   64'(err_vc), 64'd0);
      cycle(1'b0, 1'b0, 64'd0, 1'b1);

      // VC mismatch is stored and the flag sticks through clean traffic.
      cycle(1'b0, 1'b1, 64'h8000_0000_0000_0005, 1'b1);
      chk("t3_err_set", 64'(err_vc), 64'd1);
      for (int i = 0; i < 6; i++)
         cycle(1'(i % 2 == 0), 1'b1, (64'(i % 2 == 0) << 63) | 64'h20 + 64'(i), 1'b1);
      chk("t3_err_sticky", 64'(err_vc), 64'd1);

      // Back-pressure: six packets fill the FIFO and both VC slots.
      mid_reset();
      popped.delete();
      fill_six();
      #1;
      chk("t4_fifo_count", 64'(fifo_count), 64'd4);
      chk("t4_rx_count",   64'(rx_count),   64'd6);
      polarity_in = 1'b0; #1;
      chk("t4_ri_vc0", 64'(link_ri), 64'd0);
      polarity_in = 1'b1; #1;
      chk("t4_ri_vc1", 64'(link_ri), 64'd0);

      // Full FIFO: pop and pending drain in the same cycle keep count at 4.
      cycle(1'b1, 1'b0, 64'd0, 1'b1);
      chk("t5_fifo_count", 64'(fifo_count), 64'd4);
      for (int i = 0; i < 8; i++) cycle(1'(i % 2 == 0), 1'b0, 64'd0, 1'b1);
      chk("t4_pop_total", 64'(popped.size()), 64'd6);
      for (int i = 0; i < 6; i++) begin
         d = 64'h100 + 64'(i) | (64'(i % 2) << 63);
         if (i < popped.size()) chk("t4_order", popped[i], d);
      end

      // Reset mid-traffic with both VC slots and the FIFO occupied.
      fill_six();
      mid_reset();

      // Counter wrap from all-ones.
      @(negedge clk);
      force dut.rx_cnt = 16'hFFFF;
      #1;
      release dut.rx_cnt;
      m_rx = 16'hFFFF;
      cycle(1'b0, 1'b1, 64'h33, 1'b1);
      chk("t6_wrap", 64'(rx_count), 64'd0);

      // Randomized traffic, occasional VC mismatches, polarity sometimes stuck.
      mid_reset();
      p = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) != 0) p = ~p;
         d = {$urandom, $urandom};
         d[63] = ($urandom_range(0, 31) == 0) ? ~p : p;
         cycle(p, 1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
